// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round counts, rcon table and GF(2^8)/S-box helpers.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int nr_of(input int key_bits);
      return (key_bits == 256) ? 14 : 10;
   endfunction

   function automatic logic [7:0] rcon(input int idx);
      logic [7:0] rc;
      case (idx)
         0:       rc = 8'h01;
         1:       rc = 8'h02;
         2:       rc = 8'h04;
         3:       rc = 8'h08;
         4:       rc = 8'h10;
         5:       rc = 8'h20;
         6:       rc = 8'h40;
         7:       rc = 8'h80;
         8:       rc = 8'h1b;
         9:       rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] t;
      logic [7:0] inv;
      t   = x;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         t   = gmul(t, t);
         inv = gmul(inv, t);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (bypassed on the final round), AddRoundKey.
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] state_out
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   // Byte b sits at column b/4, row b%4; row r rotates left by r columns.
   always_comb begin
      state_out = '0;
      for (int b = 0; b < 16; b++) begin
         sb[b] = sbox(state_in[127-8*b -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c+r] = sb[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int b = 0; b < 16; b++) begin
         state_out[127-8*b -: 8] = (final_round ? sr[b] : mc[b]) ^ round_key[127-8*b -: 8];
      end
   end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor, 1 or 2 rounds per clock, on-the-fly key expansion.
// Optional AES_ZEROIZE_EN adds a zeroize input that wipes all state.
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int KEY_BITS         = 128,
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                clk,
   input  logic                rst,
`ifdef AES_ZEROIZE_EN
   input  logic                zeroize,
`endif
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_pt,
   input  logic [KEY_BITS-1:0] in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_ct
);

   localparam int NR    = nr_of(KEY_BITS);
   localparam int N     = NR / ROUNDS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);
   localparam int NK    = KEY_BITS / 32;

   state_t              state;
   state_t              state_next;
   logic [127:0]        s_reg;
   logic [KEY_BITS-1:0] key_win;
   logic [CNT_W-1:0]    cnt;
   logic                load;
   logic                step;
   logic                finish;
   logic                clear;
   logic                zero;
   logic [127:0]        round_out;
   logic [KEY_BITS-1:0] key_next;

`ifdef AES_ZEROIZE_EN
   assign zero = zeroize;
`else
   assign zero = 1'b0;
`endif

   // Slide the key window forward by one round key. For AES-256 the window holds two
   // round keys; odd steps use SubWord only.
   function automatic logic [KEY_BITS-1:0] key_step(input logic [KEY_BITS-1:0] win, input int r);
      logic [31:0]         w [NK];
      logic [31:0]         o [NK];
      logic [31:0]         n [4];
      logic [31:0]         t;
      logic [KEY_BITS-1:0] res;
      for (int i = 0; i < NK; i++) w[i] = win[KEY_BITS-1-32*i -: 32];
      if (NK == 4)          t = sub_word(rot_word(w[NK-1])) ^ {rcon(r), 24'h0};
      else if (r % 2 == 0)  t = sub_word(rot_word(w[NK-1])) ^ {rcon(r / 2), 24'h0};
      else                  t = sub_word(w[NK-1]);
      n[0] = w[0] ^ t;
      for (int j = 1; j < 4; j++) n[j] = n[j-1] ^ w[j];
      for (int i = 0; i < NK - 4; i++) o[i] = w[i+4];
      for (int j = 0; j < 4; j++) o[NK-4+j] = n[j];
      res = '0;
      for (int i = 0; i < NK; i++) res[KEY_BITS-1-32*i -: 32] = o[i];
      return res;
   endfunction

   for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
      logic [127:0]        rin;
      logic [127:0]        rout;
      logic [KEY_BITS-1:0] kin;
      logic [KEY_BITS-1:0] kout;
      int                  rnd;
      if (k == 0) begin : g_first
         assign rin = s_reg;
         assign kin = key_win;
      end else begin : g_next
         assign rin = g_round[k-1].rout;
         assign kin = g_round[k-1].kout;
      end
      always_comb rnd  = int'(cnt) * ROUNDS_PER_CYCLE + k;
      always_comb kout = key_step(kin, rnd);
      aes_round_comb u_round (
         .state_in    (rin),
         .round_key   (kout[KEY_BITS-1 -: 128]),
         .final_round ((rnd + 1) == NR),
         .state_out   (rout)
      );
   end

   assign round_out = g_round[ROUNDS_PER_CYCLE-1].rout;
   assign key_next  = g_round[ROUNDS_PER_CYCLE-1].kout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Zeroize overrides every other transition.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      clear      = 1'b0;
      in_ready   = 1'b0;
      out_valid  = (state == ST_DONE);
      case (state)
         ST_IDLE: begin
            in_ready = !rst && !zero;
            if (in_valid) begin
               state_next = ST_RUN;
               load       = 1'b1;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(N - 1)) begin
               state_next = ST_DONE;
               finish     = 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
               clear      = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (zero) begin
         state_next = ST_IDLE;
         load       = 1'b0;
         step       = 1'b0;
         finish     = 1'b0;
         clear      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_reg   <= '0;
         key_win <= '0;
         cnt     <= '0;
         out_ct  <= '0;
      end else if (clear) begin
         s_reg   <= '0;
         key_win <= '0;
         cnt     <= '0;
         out_ct  <= '0;
      end else if (load) begin
         s_reg   <= in_pt ^ in_key[KEY_BITS-1 -: 128];
         key_win <= in_key;
         cnt     <= '0;
      end else if (step) begin
         s_reg   <= round_out;
         key_win <= key_next;
         cnt     <= cnt + CNT_W'(1);
         if (finish) out_ct <= round_out;
      end
   end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: four configurations side by side, known vectors plus random blocks.
module tb_aes_iter_core;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   in_valid;
   logic [3:0]   out_ready;
   logic [3:0]   in_ready;
   logic [3:0]   out_valid;
   logic [127:0] in_pt;
   logic [255:0] in_key;
   logic [127:0] out_ct [4];
`ifdef AES_ZEROIZE_EN
   logic         zeroize;
`endif

   int           compared   = 0;
   int           mismatched = 0;
   logic [7:0]   tb_sbox [256];

   typedef struct {
      int           idx;
      logic [127:0] pt;
      logic [255:0] key;
      logic [127:0] ct;
      int           hold;
      bit           mutate;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   aes_iter_core #(.KEY_BITS(128), .ROUNDS_PER_CYCLE(1)) u_dut0 (
      .clk(clk), .rst(rst),
`ifdef AES_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pt(in_pt), .in_key(in_key[255:128]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ct(out_ct[0]));

   aes_iter_core #(.KEY_BITS(256), .ROUNDS_PER_CYCLE(2)) u_dut1 (
      .clk(clk), .rst(rst),
`ifdef AES_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pt(in_pt), .in_key(in_key),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ct(out_ct[1]));

   aes_iter_core #(.KEY_BITS(256), .ROUNDS_PER_CYCLE(1)) u_dut2 (
      .clk(clk), .rst(rst),
`ifdef AES_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_pt(in_pt), .in_key(in_key),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_ct(out_ct[2]));

   aes_iter_core #(.KEY_BITS(128), .ROUNDS_PER_CYCLE(2)) u_dut3 (
      .clk(clk), .rst(rst),
`ifdef AES_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_pt(in_pt), .in_key(in_key[255:128]),
      .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_ct(out_ct[3]));

   function automatic int n_of(input int idx);
      case (idx)
         0:       return 10;
         1:       return 7;
         2:       return 14;
         default: return 5;
      endcase
   endfunction

   function automatic int kbits_of(input int idx);
      return (idx == 1 || idx == 2) ? 256 : 128;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
   endfunction

   // S-box built by walking the multiplicative group with generator 3 and its inverse.
   task automatic build_sbox();
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if ((q & 8'h80) != 0) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         tb_sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      tb_sbox[0] = 8'h63;
   endtask

   // Textbook FIPS-197 cipher: full word expansion up front, then Nr rounds on a byte array.
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input int kbits);
      int           nk;
      int           nr;
      logic [31:0]  w [60];
      logic [7:0]   st [16];
      logic [7:0]   sh [16];
      logic [7:0]   rc;
      logic [31:0]  t;
      logic [127:0] res;
      nk = kbits / 32;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int b = 0; b < 16; b++) st[b] = tb_sbox[st[b]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sh[4*c+r] = st[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++) begin
            if (rnd < nr) begin
               st[4*c]   = xt(sh[4*c]) ^ xt(sh[4*c+1]) ^ sh[4*c+1] ^ sh[4*c+2] ^ sh[4*c+3];
               st[4*c+1] = sh[4*c] ^ xt(sh[4*c+1]) ^ xt(sh[4*c+2]) ^ sh[4*c+2] ^ sh[4*c+3];
               st[4*c+2] = sh[4*c] ^ sh[4*c+1] ^ xt(sh[4*c+2]) ^ xt(sh[4*c+3]) ^ sh[4*c+3];
               st[4*c+3] = xt(sh[4*c]) ^ sh[4*c] ^ sh[4*c+1] ^ sh[4*c+2] ^ xt(sh[4*c+3]);
            end else begin
               for (int r = 0; r < 4; r++) st[4*c+r] = sh[4*c+r];
            end
         end
         for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*rnd+b/4][31-8*(b%4) -: 8];
      end
      res = '0;
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
      return res;
   endfunction

   task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // One block through instance idx; hold = cycles of out_ready backpressure once DONE.
   task automatic apply_stimulus(input int idx, input logic [127:0] pt, input logic [255:0] key,
                                 input logic [127:0] exp_ct, input int hold, input bit mutate,
                                 input string tag);
      int lat;
      @(negedge clk);
      in_pt          = pt;
      in_key         = key;
      in_valid[idx]  = 1'b1;
      out_ready[idx] = (hold == 0);
      check_output({tag, " in_ready idle"}, 128'(in_ready[idx]), 128'd1);
      @(negedge clk);
      in_valid[idx] = 1'b0;
      check_output({tag, " in_ready run"}, 128'(in_ready[idx]), 128'd0);
      lat = 0;
      while (!out_valid[idx] && lat < 40) begin
         if (mutate && lat == 3) begin
            in_pt  = {$urandom, $urandom, $urandom, $urandom};
            in_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
         lat++;
      end
      check_output({tag, " latency"}, 128'(lat), 128'(n_of(idx)));
      check_output({tag, " ct"}, out_ct[idx], exp_ct);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_output({tag, " held ct"}, out_ct[idx], exp_ct);
         check_output({tag, " held in_ready"}, 128'({out_valid[idx], in_ready[idx]}), 128'b10);
      end
      out_ready[idx] = 1'b1;
      @(negedge clk);
      check_output({tag, " after handshake"},
                   {out_ct[idx][125:0], out_valid[idx], in_ready[idx]}, 128'd1);
      check_output({tag, " ct cleared"}, out_ct[idx], 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int           idx;
      int           last;
      int           accepts;
      bit           seen;
      logic [127:0] pt;
      logic [255:0] key;
      logic [127:0] exp;

      build_sbox();
      vecs[0] = '{0, 128'h3243f6a8885a308d313198a2e0370734, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0};
      vecs[1] = '{1, 128'h00112233445566778899aabbccddeeff,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0};
      vecs[2] = '{2, 128'h00112233445566778899aabbccddeeff,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0};
      vecs[3] = '{0, 128'h00112233445566778899aabbccddeeff, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20, 1'b0};
      vecs[4] = '{3, 128'h00112233445566778899aabbccddeeff, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, 1'b0};
      vecs[5] = '{0, 128'h3243f6a8885a308d313198a2e0370734, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b1};

      in_valid  = '0;
      out_ready = '0;
      in_pt     = '0;
      in_key    = '0;
`ifdef AES_ZEROIZE_EN
      zeroize   = 1'b0;
`endif
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset out_valid", 128'(out_valid), 128'd0);
      check_output("reset in_ready", 128'(in_ready), 128'd0);
      check_output("reset out_ct", out_ct[0] | out_ct[1] | out_ct[2] | out_ct[3], 128'd0);
      rst = 1'b0;
      #1;
      check_output("release in_ready", 128'(in_ready), 128'hf);

      for (int v = 0; v < 6; v++)
         apply_stimulus(vecs[v].idx, vecs[v].pt, vecs[v].key, vecs[v].ct, vecs[v].hold,
                        vecs[v].mutate, $sformatf("vec%0d", v));

      for (int r = 0; r < 10; r++) begin
         idx = $urandom_range(0, 3);
         pt  = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         exp = aes_ref(pt, key, kbits_of(idx));
         apply_stimulus(idx, pt, key, exp, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", r));
      end

      // Back-to-back blocks with the sink always ready: accepts spaced N+2 cycles.
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      exp = aes_ref(pt, key, 128);
      @(negedge clk);
      in_pt        = pt;
      in_key       = key;
      in_valid[3]  = 1'b1;
      out_ready[3] = 1'b1;
      last    = -1;
      accepts = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (out_valid[3]) check_output("b2b ct", out_ct[3], exp);
         if (in_ready[3]) begin
            if (last >= 0) check_output("b2b spacing", 128'(cyc - last), 128'd7);
            last = cyc;
            accepts++;
         end
         @(negedge clk);
      end
      in_valid[3] = 1'b0;
      check_output("b2b accepts", 128'(accepts), 128'd6);
      repeat (10) @(negedge clk);
      out_ready[3] = 1'b0;

      // Reset four cycles into a block: it is never emitted.
      @(negedge clk);
      in_pt        = vecs[0].pt;
      in_key       = vecs[0].key;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("midrun rst outputs", {out_ct[0][125:0], out_valid[0], in_ready[0]}, 128'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         seen = seen | out_valid[0];
      end
      check_output("midrun rst no output", 128'(seen), 128'd0);
      check_output("midrun rst in_ready", 128'(in_ready[0]), 128'd1);
      apply_stimulus(0, vecs[0].pt, vecs[0].key, vecs[0].ct, 0, 1'b0, "post rst");

`ifdef AES_ZEROIZE_EN
      @(negedge clk);
      in_pt        = vecs[3].pt;
      in_key       = vecs[3].key;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b0;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (12) @(negedge clk);
      check_output("zeroize pre done", out_ct[0], vecs[3].ct);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      check_output("zeroize in done", {out_ct[0][125:0], out_valid[0], in_ready[0]}, 128'd1);
      zeroize     = 1'b1;
      in_valid[0] = 1'b1;
      #1;
      check_output("zeroize blocks in_ready", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
      zeroize     = 1'b0;
      in_valid[0] = 1'b0;
      check_output("zeroize no accept", 128'(in_ready[0]), 128'd1);
      repeat (12) @(negedge clk);
      check_output("zeroize no output", 128'(out_valid[0]), 128'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
